sponge_squeeze_stream: RTL and testbench
========================================

# sponge_squeeze_stream

Parametrised squeeze stage for the sponge-based hash/XOF datapath. It takes the post-absorb state (rate `r`, capacity `c`) and extracts an arbitrary-length output, invoking the external permutation core between rate blocks over a start/done handshake. Output is delivered either packed into one MSB-aligned register or streamed block by block with valid/ready. It adds variable rate width, stream mode, abort, and length-error reporting to the existing squeeze stage.

## Interface
- `CWIDTH`, 320, capacity width in bits
- `RWIDTH`, 32, rate block width in bits (≥1)
- `OUT_WIDTH`, 320, packed digest register width (≥ RWIDTH)
- `LEN_WIDTH`, 20, width of requested output length (bits)
- `ROUND_COUNT`, 10, width of the rounds field passed to the permutation

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `start`  in  1  begin squeeze; sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE without `done`
- `stream_mode`  in  1  0 = packed into `digest`, 1 = per-block stream; latched at start
- `big`  in  1  0 = single-bit mode (emit `r_in[0]` only), 1 = normal; latched at start
- `c_in`  in  CWIDTH  initial capacity
- `r_in`  in  RWIDTH  initial rate block
- `out_len`  in  LEN_WIDTH  requested output length in bits
- `rounds`  in  ROUND_COUNT  forwarded unchanged to `p_rounds`
- `p_start`  out  1  one-cycle permutation request
- `p_c`, `p_r`  out  CWIDTH, RWIDTH  state presented to permutation (held stable from `p_start` until `p_done`)
- `p_rounds`  out  ROUND_COUNT  equals `rounds`
- `p_done`  in  1  permutation result valid
- `p_c_res`, `p_r_res`  in  CWIDTH, RWIDTH  permutation result
- `digest`  out  OUT_WIDTH  packed output, MSB-aligned, unused low bits zero
- `blk_data`  out  RWIDTH  stream block, MSB-aligned, unused low bits zero
- `blk_valid`, `blk_last`  out  1  stream valid / final block
- `blk_bits`  out  $clog2(RWIDTH+1)  valid bits in `blk_data`
- `blk_ready`  in  1  stream consumer ready
- `busy`, `done`, `len_err`  out  1  active / one-cycle completion pulse / length clamped

## Operation
- States: IDLE, EMIT, PERM_REQ, PERM_WAIT, DONE.
- IDLE: on `start`, latch `c_in`, `r_in`, `stream_mode`, `big`, and remaining = `out_len`; clear `digest` and consumed count; go to EMIT. If `big`=0, remaining is forced to 1. If `stream_mode`=0 and `out_len` > OUT_WIDTH, remaining = OUT_WIDTH and `len_err`=1 (held until next start). If remaining = 0, go directly to DONE.
- EMIT: k = min(remaining, RWIDTH); the emitted bits are the top k bits of the rate register, `r[RWIDTH-1 -: k]`, except in `big`=0 mode, where the emitted bit is `r[0]`.
  - Packed: write these bits to `digest[OUT_WIDTH-1-consumed -: k]`; consumed += k; remaining -= k; advance in one cycle.
  - Stream: `blk_valid`=1; `blk_bits`=k; `blk_last`=(remaining==k); advance only on `blk_valid && blk_ready`.
  - After the transfer, if remaining > 0, go to PERM_REQ; otherwise go to DONE.
- PERM_REQ: `p_start`=1 for exactly one cycle; `p_c`/`p_r` = current registers; go to PERM_WAIT.
- PERM_WAIT: on `p_done`, load the rate/capacity registers from `p_r_res`/`p_c_res` and go to EMIT. `p_done` outside PERM_WAIT is ignored.
- DONE: `done`=1 for one cycle, then IDLE. `digest` holds its value until the next accepted `start`.
- No permutation is issued after the final block. Permutation calls = ceil(len/RWIDTH) − 1.
- `abort` (any non-IDLE state): next state is IDLE; `blk_valid` and `p_start` drop; `done` does not fire; `digest` is left partially filled.
- `start` while not in IDLE is ignored.

## Timing
- Reset values: state IDLE; `digest`, `blk_data`, `blk_bits` = 0; `blk_valid`, `blk_last`, `p_start`, `busy`, `done`, `len_err` = 0; `p_c`, `p_r` = 0.
- `busy`=1 in every state except IDLE (DONE included).
- Packed, single block (len ≤ RWIDTH): `start` in cycle 0, EMIT in cycle 1, `done` in cycle 2.
- Each extra block adds 1 (PERM_REQ) + W (PERM_WAIT cycles up to and including `p_done`) + 1 (EMIT).
- `p_done` is sampled no earlier than the cycle after `p_start`.
- Stream: EMIT lasts until the handshake cycle. `blk_data`, `blk_bits` and `blk_last` remain stable while `blk_valid`=1 and `blk_ready`=0.
- `abort` has priority over `blk_ready` and `p_done` in the same cycle.
- A reset assertion mid-operation clears everything asynchronously. After deassertion the block waits in IDLE for a new `start`.

## Test plan
- Packed, RWIDTH=32, len=64, `r_in`=0xDEADBEEF, permutation model returns `p_r_res`=0x12345678 with `p_done` 3 cycles after `p_start` -> `digest[319:256]`=0xDEADBEEF_12345678, rest 0; exactly one `p_start`; `done` in cycle 7.
- Packed, len=40 -> second block contributes its top 8 bits at `digest[287:280]`; `digest[279:0]`=0; `len_err`=0.
- Stream, len=72, `blk_ready` low for 5 cycles on block 1 -> three blocks with `blk_bits` 32, 32, 8; only the third has `blk_last`=1; data stable while stalled; two permutation calls.
- Edge lengths: len=0 -> `done` in cycle 1, no `p_start`, `digest`=0. `big`=0 with `r_in[0]`=1 -> `digest[319]`=1, no permutation. Packed len=400 -> `len_err`=1, 320 bits filled, 9 permutation calls.
- `abort` during PERM_WAIT -> IDLE next cycle, no `done`. A following `start` completes normally.
- `reset`=0 asserted mid-stream -> all outputs 0 immediately; `start` after release completes a fresh len=32 squeeze correctly.

Source files
------------

// File: rtl/sponge_squeeze_stream.sv
// Squeeze stage of the sponge datapath: emits rate bits packed into an MSB-aligned
// digest or as a valid/ready block stream, calling the external permutation between blocks.
module sponge_squeeze_stream #(
  parameter int CWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int OUT_WIDTH   = 320,
  parameter int LEN_WIDTH   = 20,
  parameter int ROUND_COUNT = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         stream_mode,
  input  logic                         big,
  input  logic [CWIDTH-1:0]            c_in,
  input  logic [RWIDTH-1:0]            r_in,
  input  logic [LEN_WIDTH-1:0]         out_len,
  input  logic [ROUND_COUNT-1:0]       rounds,
  output logic                         p_start,
  output logic [CWIDTH-1:0]            p_c,
  output logic [RWIDTH-1:0]            p_r,
  output logic [ROUND_COUNT-1:0]       p_rounds,
  input  logic                         p_done,
  input  logic [CWIDTH-1:0]            p_c_res,
  input  logic [RWIDTH-1:0]            p_r_res,
  output logic [OUT_WIDTH-1:0]         digest,
  output logic [RWIDTH-1:0]            blk_data,
  output logic                         blk_valid,
  output logic                         blk_last,
  output logic [$clog2(RWIDTH+1)-1:0]  blk_bits,
  input  logic                         blk_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         len_err
);

  localparam int KW   = $clog2(RWIDTH + 1);
  localparam int CNTW = $clog2(OUT_WIDTH + 1);
  localparam logic [LEN_WIDTH-1:0] RW_LEN  = LEN_WIDTH'(RWIDTH);
  localparam logic [LEN_WIDTH-1:0] OUT_LEN = LEN_WIDTH'(OUT_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_EMIT, S_PERM_REQ, S_PERM_WAIT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CWIDTH-1:0]      c_q, c_d;
  logic [RWIDTH-1:0]      r_q, r_d;
  logic                   stream_q, stream_d;
  logic                   big_q, big_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [CNTW-1:0]        cons_q, cons_d;
  logic [OUT_WIDTH-1:0]   digest_q, digest_d;
  logic                   len_err_q, len_err_d;

  logic [KW-1:0]          k;
  logic [RWIDTH-1:0]      emit_blk;
  logic [OUT_WIDTH-1:0]   emit_pos;
  logic                   last_blk;

  // Current block: top k rate bits (or r[0] alone in single-bit mode), MSB-aligned.
  always_comb begin
    k = (rem_q >= RW_LEN) ? KW'(RWIDTH) : KW'(rem_q);
    if (big_q) begin
      emit_blk = r_q & ~({RWIDTH{1'b1}} >> k);
    end else begin
      emit_blk = '0;
      emit_blk[RWIDTH-1] = r_q[0];
    end
    emit_pos = OUT_WIDTH'(emit_blk) << (OUT_WIDTH - RWIDTH);
    emit_pos = emit_pos >> cons_q;
    last_blk = (rem_q == LEN_WIDTH'(k));
  end

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    r_d       = r_q;
    stream_d  = stream_q;
    big_d     = big_q;
    rem_d     = rem_q;
    cons_d    = cons_q;
    digest_d  = digest_q;
    len_err_d = len_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d       = c_in;
          r_d       = r_in;
          stream_d  = stream_mode;
          big_d     = big;
          digest_d  = '0;
          cons_d    = '0;
          len_err_d = 1'b0;
          rem_d     = big ? out_len : LEN_WIDTH'(1);
          if (!stream_mode && big && (out_len > OUT_LEN)) begin
            rem_d     = OUT_LEN;
            len_err_d = 1'b1;
          end
          state_d = (rem_d == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        if (!stream_q || blk_ready) begin
          rem_d  = rem_q - LEN_WIDTH'(k);
          cons_d = cons_q + CNTW'(k);
          if (!stream_q) digest_d = digest_q | emit_pos;
          state_d = last_blk ? S_DONE : S_PERM_REQ;
        end
      end
      S_PERM_REQ: state_d = S_PERM_WAIT;
      S_PERM_WAIT: begin
        if (p_done) begin
          r_d     = p_r_res;
          c_d     = p_c_res;
          state_d = S_EMIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any transfer or permutation result landing in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      c_d      = c_q;
      r_d      = r_q;
      rem_d    = rem_q;
      cons_d   = cons_q;
      digest_d = digest_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      r_q       <= '0;
      stream_q  <= 1'b0;
      big_q     <= 1'b0;
      rem_q     <= '0;
      cons_q    <= '0;
      digest_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      r_q       <= r_d;
      stream_q  <= stream_d;
      big_q     <= big_d;
      rem_q     <= rem_d;
      cons_q    <= cons_d;
      digest_q  <= digest_d;
      len_err_q <= len_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign p_start   = (state_q == S_PERM_REQ);
  assign p_c       = c_q;
  assign p_r       = r_q;
  assign p_rounds  = rounds;
  assign digest    = digest_q;
  assign len_err   = len_err_q;
  assign blk_valid = (state_q == S_EMIT) && stream_q;
  assign blk_data  = blk_valid ? emit_blk : '0;
  assign blk_bits  = blk_valid ? k : '0;
  assign blk_last  = blk_valid && last_blk;

endmodule

// File: tb/tb_sponge_squeeze_stream.sv
// Bench for sponge_squeeze_stream: directed vector table, abort/reset sequences and
// randomized runs checked against a bit-queue squeeze model.
module tb_sponge_squeeze_stream;
  localparam int CW = 320, RW = 32, OW = 320, LW = 20, RC = 10;

  logic clk, reset, start, abort, stream_mode, big, p_start, p_done;
  logic [CW-1:0] c_in, p_c, p_c_res;
  logic [RW-1:0] r_in, p_r, p_r_res, blk_data;
  logic [LW-1:0] out_len;
  logic [RC-1:0] rounds, p_rounds;
  logic [OW-1:0] digest;
  logic blk_valid, blk_last, blk_ready, busy, done, len_err;
  logic [5:0] blk_bits;

  sponge_squeeze_stream #(.CWIDTH(CW), .RWIDTH(RW), .OUT_WIDTH(OW), .LEN_WIDTH(LW),
                          .ROUND_COUNT(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stream_mode(stream_mode),
    .big(big), .c_in(c_in), .r_in(r_in), .out_len(out_len), .rounds(rounds),
    .p_start(p_start), .p_c(p_c), .p_r(p_r), .p_rounds(p_rounds), .p_done(p_done),
    .p_c_res(p_c_res), .p_r_res(p_r_res), .digest(digest), .blk_data(blk_data),
    .blk_valid(blk_valid), .blk_last(blk_last), .blk_bits(blk_bits),
    .blk_ready(blk_ready), .busy(busy), .done(done), .len_err(len_err));

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Permutation stand-in: fixed mode returns 0x12345678, otherwise a simple mix.
  int lat = 3, pcount = 0, cnt = 0;
  bit fixed_perm = 1;
  logic [RW-1:0] held_r;
  logic [CW-1:0] held_c;

  function automatic logic [RW-1:0] perm_r(input logic [RW-1:0] r, input logic [CW-1:0] c);
    if (fixed_perm) return 32'h12345678;
    return {r[26:0], r[31:27]} ^ c[31:0] ^ 32'h9E3779B9;
  endfunction

  function automatic logic [CW-1:0] perm_c(input logic [RW-1:0] r, input logic [CW-1:0] c);
    if (fixed_perm) return c;
    return {c[CW-2:0], c[CW-1]} ^ {288'd0, r};
  endfunction

  initial begin
    p_done = 0; p_r_res = '0; p_c_res = '0;
    forever begin
      @(negedge clk);
      p_done = 0;
      if (!reset) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("p_r_stable", p_r, held_r);
          chk("p_c_stable", p_c, held_c);
          p_r_res = perm_r(p_r, p_c);
          p_c_res = perm_c(p_r, p_c);
          p_done = 1;
        end
      end
      if (p_start) begin
        pcount++;
        cnt = lat;
        held_r = p_r;
        held_c = p_c;
      end
    end
  end

  // Reference: collect the emitted bit sequence, then lay it out as digest and blocks.
  logic [OW-1:0] m_dig;
  int m_calls, m_nb;
  bit m_err;
  logic [RW-1:0] m_bd[$];
  int m_bb[$];

  task automatic model_run(input logic [CW-1:0] c, input logic [RW-1:0] r, input int len,
                           input bit bg, input bit sm);
    int n;
    int k;
    bit q[$];
    n = len; m_err = 0; m_calls = 0; m_dig = '0;
    m_bd.delete(); m_bb.delete();
    if (!bg) n = 1;
    else if (!sm && n > OW) begin n = OW; m_err = 1; end
    for (int e = 0; e < n; ) begin
      logic [RW-1:0] w;
      k = (n - e < RW) ? n - e : RW;
      w = '0;
      for (int i = 0; i < k; i++) begin
        bit b;
        b = bg ? r[RW-1-i] : r[0];
        q.push_back(b);
        w[RW-1-i] = b;
      end
      m_bd.push_back(w);
      m_bb.push_back(k);
      e += k;
      if (e < n) begin
        logic [RW-1:0] r2;
        r2 = perm_r(r, c);
        c = perm_c(r, c);
        r = r2;
        m_calls++;
      end
    end
    if (!sm) for (int j = 0; j < q.size(); j++) m_dig[OW-1-j] = q[j];
    m_nb = m_bd.size();
  endtask

  typedef struct {
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    int len;
    bit bg;
    bit sm;
    int lat;
    bit fixed;
    int stall_blk;
    int stall_n;
    bit chk_const;
    logic [OW-1:0] exp_dig;
    int exp_cyc;
    int exp_calls;
    bit exp_err;
  } vec_t;

  vec_t tv[9];

  task automatic run_case(input int id, input vec_t v, input bit rnd_rdy);
    int cyc, done_cyc, blk_idx, stall_left, exp_cyc;
    bit pstall;
    logic [RW-1:0] pd;
    logic [5:0] pb;
    logic pl;
    logic [RW-1:0] od[$];
    int ob[$];
    bit ol[$];
    lat = v.lat; fixed_perm = v.fixed; pcount = 0;
    model_run(v.c, v.r, v.len, v.bg, v.sm);
    c_in = v.c; r_in = v.r; out_len = LW'(v.len); big = v.bg; stream_mode = v.sm;
    blk_ready = 0; start = 1;
    tick();
    start = 0; cyc = 1; done_cyc = -1; blk_idx = 0; stall_left = v.stall_n; pstall = 0;
    pd = '0; pb = '0; pl = 0;
    while (cyc < 2000 && done_cyc < 0) begin
      if (done) done_cyc = cyc;
      if (blk_valid) begin
        if (pstall) begin
          chk($sformatf("v%0d_stall_data", id), blk_data, pd);
          chk($sformatf("v%0d_stall_bits", id), blk_bits, pb);
          chk($sformatf("v%0d_stall_last", id), blk_last, pl);
        end
        if (rnd_rdy) blk_ready = ($urandom_range(0, 3) != 0);
        else if (blk_idx == v.stall_blk && stall_left > 0) begin
          blk_ready = 0;
          stall_left--;
        end else blk_ready = 1;
        if (blk_ready) begin
          od.push_back(blk_data); ob.push_back(int'(blk_bits)); ol.push_back(blk_last);
          blk_idx++; pstall = 0;
        end else begin
          pstall = 1; pd = blk_data; pb = blk_bits; pl = blk_last;
        end
      end else begin
        blk_ready = 0; pstall = 0;
      end
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    blk_ready = 0;
    if (done_cyc < 0) chk($sformatf("v%0d_done_timeout", id), 0, 1);
    chk($sformatf("v%0d_digest", id), digest, m_dig);
    chk($sformatf("v%0d_len_err", id), len_err, m_err);
    chk($sformatf("v%0d_perm_calls", id), pcount, m_calls);
    if (!rnd_rdy) begin
      exp_cyc = (m_nb == 0) ? 1 : 1 + m_nb + (m_nb - 1) * (1 + v.lat) +
                ((v.sm && v.stall_blk >= 0 && v.stall_blk < m_nb) ? v.stall_n : 0);
      chk($sformatf("v%0d_done_cycle", id), done_cyc, exp_cyc);
    end
    chk($sformatf("v%0d_blk_count", id), od.size(), v.sm ? m_nb : 0);
    for (int i = 0; i < od.size() && i < m_nb; i++) begin
      chk($sformatf("v%0d_blk%0d_data", id, i), od[i], m_bd[i]);
      chk($sformatf("v%0d_blk%0d_bits", id, i), ob[i], m_bb[i]);
      chk($sformatf("v%0d_blk%0d_last", id, i), ol[i], (i == m_nb - 1));
    end
    if (v.chk_const) begin
      chk($sformatf("v%0d_digest_tbl", id), digest, v.exp_dig);
      chk($sformatf("v%0d_calls_tbl", id), pcount, v.exp_calls);
      chk($sformatf("v%0d_err_tbl", id), len_err, v.exp_err);
      chk($sformatf("v%0d_cycle_tbl", id), done_cyc, v.exp_cyc);
    end
    tick();
    chk($sformatf("v%0d_done_pulse", id), done, 0);
    chk($sformatf("v%0d_idle", id), busy, 0);
    repeat (2) tick();
  endtask

  initial begin
    bit seen;
    vec_t rv;
    reset = 0; start = 0; abort = 0; stream_mode = 0; big = 1; c_in = '0; r_in = '0;
    out_len = '0; rounds = 10'h2A5; blk_ready = 0;

    tv[0] = '{c:'0, r:32'hDEADBEEF, len:64, bg:1, sm:0, lat:3, fixed:1, stall_blk:-1,
              stall_n:0, chk_const:1, exp_dig:{32'hDEADBEEF, 32'h12345678, 256'd0},
              exp_cyc:7, exp_calls:1, exp_err:0};
    tv[1] = '{c:'0, r:32'hDEADBEEF, len:40, bg:1, sm:0, lat:3, fixed:1, stall_blk:-1,
              stall_n:0, chk_const:1, exp_dig:{32'hDEADBEEF, 8'h12, 280'd0},
              exp_cyc:7, exp_calls:1, exp_err:0};
    tv[2] = '{c:'0, r:32'hDEADBEEF, len:72, bg:1, sm:1, lat:3, fixed:1, stall_blk:1,
              stall_n:5, chk_const:1, exp_dig:'0, exp_cyc:17, exp_calls:2, exp_err:0};
    tv[3] = '{c:'0, r:32'hDEADBEEF, len:0, bg:1, sm:0, lat:3, fixed:1, stall_blk:-1,
              stall_n:0, chk_const:1, exp_dig:'0, exp_cyc:1, exp_calls:0, exp_err:0};
    tv[4] = '{c:'0, r:32'h00000001, len:100, bg:0, sm:0, lat:3, fixed:1, stall_blk:-1,
              stall_n:0, chk_const:1, exp_dig:{1'b1, 319'd0}, exp_cyc:2, exp_calls:0,
              exp_err:0};
    tv[5] = '{c:'0, r:32'hDEADBEEF, len:400, bg:1, sm:0, lat:3, fixed:1, stall_blk:-1,
              stall_n:0, chk_const:1, exp_dig:{32'hDEADBEEF, {9{32'h12345678}}},
              exp_cyc:47, exp_calls:9, exp_err:1};
    tv[6] = '{c:'0, r:32'hCAFEBABE, len:32, bg:1, sm:0, lat:2, fixed:1, stall_blk:-1,
              stall_n:0, chk_const:1, exp_dig:{32'hCAFEBABE, 288'd0}, exp_cyc:2,
              exp_calls:0, exp_err:0};
    tv[7] = '{c:{10{32'hA5C3_0F1E}}, r:32'h0BADF00D, len:320, bg:1, sm:0, lat:1, fixed:0,
              stall_blk:-1, stall_n:0, chk_const:0, exp_dig:'0, exp_cyc:0, exp_calls:0,
              exp_err:0};
    tv[8] = '{c:{10{32'h1357_9BDF}}, r:32'h89ABCDEF, len:33, bg:1, sm:1, lat:4, fixed:0,
              stall_blk:0, stall_n:2, chk_const:0, exp_dig:'0, exp_cyc:0, exp_calls:0,
              exp_err:0};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digest", digest, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_p_start", p_start, 0);
    chk("rst_p_r", p_r, 0);
    chk("rst_len_err", len_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    tick();
    chk("p_rounds", p_rounds, 10'h2A5);

    for (int i = 0; i < 9; i++) begin
      run_case(i, tv[i], 0);
      if (tv[i].exp_err) chk("len_err_hold", len_err, 1);
    end

    // Abort while waiting on the permutation.
    lat = 3; fixed_perm = 1; c_in = '0; r_in = 32'hDEADBEEF; out_len = 64; big = 1;
    stream_mode = 0; start = 1;
    tick();
    start = 0;
    tick();
    chk("abort_p_start", p_start, 1);
    tick();
    chk("abort_busy_wait", busy, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_idle", busy, 0);
    chk("abort_digest", digest, {32'hDEADBEEF, 288'd0});
    seen = done;
    repeat (6) begin
      tick();
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    run_case(20, tv[0], 0);

    // Asynchronous reset in the middle of a stream block.
    lat = 3; fixed_perm = 1; r_in = 32'h55AA55AA; out_len = 72; stream_mode = 1;
    blk_ready = 0; start = 1;
    tick();
    start = 0;
    chk("mid_blk_valid", blk_valid, 1);
    #2 reset = 0;
    #1;
    chk("arst_blk_valid", blk_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_blk_data", blk_data, 0);
    chk("arst_blk_bits", blk_bits, 0);
    chk("arst_p_r", p_r, 0);
    chk("arst_digest", digest, 0);
    @(negedge clk) reset = 1;
    tick();
    chk("arst_still_idle", busy, 0);
    run_case(21, tv[6], 0);

    for (int n = 0; n < 25; n++) begin
      for (int w = 0; w < 10; w++) rv.c[w*32 +: 32] = $urandom;
      rv.r = $urandom;
      rv.len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 400);
      rv.bg = ($urandom_range(0, 7) != 0);
      rv.sm = $urandom_range(0, 1);
      rv.lat = $urandom_range(1, 4);
      rv.fixed = 0;
      rv.stall_blk = -1; rv.stall_n = 0; rv.chk_const = 0;
      rv.exp_dig = '0; rv.exp_cyc = 0; rv.exp_calls = 0; rv.exp_err = 0;
      run_case(100 + n, rv, rv.sm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
